// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM target for the CPU memory port.
// A request is sampled in IDLE, held for WAIT_STATES cycles, then answered
// with a one-cycle mem_ready pulse. mem_error marks a rejected request.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] memory_addr,
   input  logic [31:0] data_to_memory,
   input  logic        read_from_memory,
   input  logic        write_to_memory,
   output logic [31:0] data_from_memory,
   output logic        mem_ready,
   output logic        mem_error
);

   localparam int unsigned AW          = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESPOND
   } state_t;

   typedef enum logic [1:0] {
      OP_READ,
      OP_WRITE,
      OP_BAD
   } op_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   op_t         r_op;
   logic        r_err;
   logic        r_ready;
   logic        r_error;
   logic [31:0] r_rdata;

   // NOTE: the RAM has no reset; its contents are undefined after power-up
   // and survive rst, which lets it map onto plain block RAM.
   logic [31:0] r_mem [DEPTH_WORDS];

   logic          w_req;
   op_t           w_op;
   logic [31:0]   w_acc_addr;
   logic [31:0]   w_acc_data;
   op_t           w_acc_op;
   logic [31:0]   w_off;
   logic          w_bad;
   logic [AW-1:0] w_idx;
   logic          w_enter_resp;

   // Decode the incoming request and pick the request being committed: the
   // live inputs when responding straight from IDLE, the latched copy otherwise.
   always_comb begin
      w_req = read_from_memory | write_to_memory;
      if (read_from_memory && write_to_memory) begin
         w_op = OP_BAD;
      end else if (write_to_memory) begin
         w_op = OP_WRITE;
      end else begin
         w_op = OP_READ;
      end

      if (r_state == ST_IDLE) begin
         w_acc_addr = memory_addr;
         w_acc_data = data_to_memory;
         w_acc_op   = w_op;
      end else begin
         w_acc_addr = r_addr;
         w_acc_data = r_wdata;
         w_acc_op   = r_op;
      end

      // Unsigned subtraction: addresses below the base wrap to huge offsets
      // and fall out of range. With DEPTH_WORDS a power of two, any set bit
      // above the word index means offset >= DEPTH_WORDS*4.
      w_off = w_acc_addr - BASE_ADDR;
      w_bad = (w_acc_op == OP_BAD) || (w_off[1:0] != 2'b00) || (|w_off[31:AW+2]);
      w_idx = w_off[AW+1:2];

      w_enter_resp = ((r_state == ST_IDLE) && w_req && (WAIT_STATES == 0)) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd0));
   end

   // Request FSM with registered completion outputs and read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_op    <= OP_READ;
         r_err   <= 1'b0;
         r_ready <= 1'b0;
         r_error <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every
         // register sees the pre-edge values of the others.
         r_ready <= (r_state == ST_RESPOND);
         r_error <= (r_state == ST_RESPOND) && r_err;

         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_addr  <= memory_addr;
                  r_wdata <= data_to_memory;
                  r_op    <= w_op;
                  if (WAIT_STATES == 0) begin
                     r_state <= ST_RESPOND;
                  end else begin
                     r_cnt   <= LP_CNT_INIT;
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RESPOND;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESPOND: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         if (w_enter_resp) begin
            r_err <= w_bad;
            if (!w_bad && (w_acc_op == OP_READ)) begin
               r_rdata <= r_mem[w_idx];
            end
         end
      end
   end

   // RAM write port: commits only on the edge entering RESPOND, never in reset.
   always_ff @(posedge clk) begin
      if (rst && w_enter_resp && !w_bad && (w_acc_op == OP_WRITE)) begin
         r_mem[w_idx] <= w_acc_data;
      end
   end

   assign data_from_memory = r_rdata;
   assign mem_ready        = r_ready;
   assign mem_error        = r_error;

endmodule
